// File: rtl/uart_tl_packet_queue_bridge.sv
// Queues 16-byte UART TileLink packets and presents them in order as TileLink
// frames to the serializer, with channel filtering and a synchronised handshake.
module uart_tl_packet_queue_bridge #(
  parameter int          DEPTH       = 4,
  parameter int          SYNC_STAGES = 2,
  parameter bit          EDGE_QUAL   = 1'b1,
  parameter logic [7:0]  CHAN_MASK   = 8'h09,
  parameter logic [7:0]  SOURCE_ID   = 8'h00
) (
  input  logic                         sysclk,
  input  logic                         reset,
  input  logic                         tl_clk,
  input  logic                         packet_valid,
  output logic                         packet_ready,
  input  logic [127:0]                 packet_data,
  output logic                         tl_ser_in_valid,
  input  logic                         tl_ser_in_ready,
  output logic [2:0]                   tl_in_bits_chanId,
  output logic [2:0]                   tl_in_bits_opcode,
  output logic [2:0]                   tl_in_bits_param,
  output logic                         tl_in_bits_corrupt,
  output logic [7:0]                   tl_in_bits_size,
  output logic [8:0]                   tl_in_bits_union,
  output logic [63:0]                  tl_in_bits_address,
  output logic [63:0]                  tl_in_bits_data,
  output logic [7:0]                   tl_in_bits_source,
  output logic                         tl_in_bits_last,
  output logic [$clog2(DEPTH+1)-1:0]   fifo_level,
  output logic [15:0]                  drop_count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int LW = $clog2(DEPTH + 1);

  logic [127:0]           mem [DEPTH];
  logic [AW-1:0]          wr_ptr;
  logic [AW-1:0]          rd_ptr;
  logic [SYNC_STAGES-1:0] rdy_sync;
  logic [SYNC_STAGES-1:0] clk_sync;
  logic                   clk_prev;
  logic                   rdy_s;
  logic                   clk_s;
  logic                   edge_ok;
  logic                   accept;
  logic                   legal;
  logic                   push;
  logic                   drop;
  logic                   fire;
  logic [127:0]           head;
  logic                   unused_head;

  assign packet_ready    = (fifo_level != LW'(DEPTH));
  assign tl_ser_in_valid = (fifo_level != '0);

  assign accept = packet_valid & packet_ready;
  assign legal  = (packet_data[7:3] == 5'd0) && CHAN_MASK[packet_data[2:0]];
  assign push   = accept & legal;
  assign drop   = accept & ~legal;

  assign rdy_s   = rdy_sync[SYNC_STAGES-1];
  assign clk_s   = clk_sync[SYNC_STAGES-1];
  assign edge_ok = EDGE_QUAL ? (clk_s & ~clk_prev) : 1'b1;
  assign fire    = tl_ser_in_valid & rdy_s & edge_ok;

  // Both tl_ser_in_ready and tl_clk cross from the serializer domain as plain data.
  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      rdy_sync <= '0;
      clk_sync <= '0;
      clk_prev <= 1'b0;
    end else begin
      rdy_sync[0] <= tl_ser_in_ready;
      clk_sync[0] <= tl_clk;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        rdy_sync[i] <= rdy_sync[i-1];
        clk_sync[i] <= clk_sync[i-1];
      end
      clk_prev <= clk_s;
    end
  end

  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
      drop_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (fire) rd_ptr <= rd_ptr + AW'(1);
      case ({push, fire})
        2'b10:   fifo_level <= fifo_level + LW'(1);
        2'b01:   fifo_level <= fifo_level - LW'(1);
        default: fifo_level <= fifo_level;
      endcase
      if (drop && (drop_count != 16'hFFFF)) drop_count <= drop_count + 16'd1;
    end
  end

  // Storage is not reset; validity is tracked solely by fifo_level.
  always_ff @(posedge sysclk) begin
    if (push) mem[wr_ptr] <= packet_data;
  end

  assign head = mem[rd_ptr];

  assign tl_in_bits_chanId  = head[2:0];
  assign tl_in_bits_opcode  = head[10:8];
  assign tl_in_bits_param   = head[14:12];
  assign tl_in_bits_corrupt = head[15];
  assign tl_in_bits_size    = head[23:16];
  assign tl_in_bits_union   = {1'b0, head[31:24]};
  assign tl_in_bits_address = {32'h0, head[63:32]};
  assign tl_in_bits_data    = head[127:64];
  assign tl_in_bits_source  = SOURCE_ID;
  assign tl_in_bits_last    = 1'b1;

  assign unused_head = ^{head[11], head[7:3]};

endmodule

// File: tb/tb_uart_tl_packet_queue_bridge.sv
// Scoreboard bench for uart_tl_packet_queue_bridge: edge-qualified main instance
// plus a free-running (EDGE_QUAL=0) instance for the per-cycle transfer case.
module tb_uart_tl_packet_queue_bridge;

  logic         sysclk;
  logic         reset;
  logic         tl_clk;
  logic         packet_valid;
  logic         packet_ready;
  logic [127:0] packet_data;
  logic         tl_ser_in_valid;
  logic         tl_ser_in_ready;
  logic [2:0]   tl_in_bits_chanId;
  logic [2:0]   tl_in_bits_opcode;
  logic [2:0]   tl_in_bits_param;
  logic         tl_in_bits_corrupt;
  logic [7:0]   tl_in_bits_size;
  logic [8:0]   tl_in_bits_union;
  logic [63:0]  tl_in_bits_address;
  logic [63:0]  tl_in_bits_data;
  logic [7:0]   tl_in_bits_source;
  logic         tl_in_bits_last;
  logic [2:0]   fifo_level;
  logic [15:0]  drop_count;

  logic         packet_valid0;
  logic         packet_ready0;
  logic [127:0] packet_data0;
  logic         tl_ser_in_valid0;
  logic         tl_ser_in_ready0;
  logic [2:0]   chan0;
  logic [2:0]   opcode0;
  logic [2:0]   param0;
  logic         corrupt0;
  logic [7:0]   size0;
  logic [8:0]   union0;
  logic [63:0]  address0;
  logic [63:0]  data0;
  logic [7:0]   source0;
  logic         last0;
  logic [2:0]   fifo_level0;
  logic [15:0]  drop_count0;
  logic         tl_clk0;

  int errors = 0;
  int checks = 0;
  logic [127:0] sb [$];
  logic [127:0] sb0 [$];

  uart_tl_packet_queue_bridge dut (
    .sysclk(sysclk), .reset(reset), .tl_clk(tl_clk),
    .packet_valid(packet_valid), .packet_ready(packet_ready), .packet_data(packet_data),
    .tl_ser_in_valid(tl_ser_in_valid), .tl_ser_in_ready(tl_ser_in_ready),
    .tl_in_bits_chanId(tl_in_bits_chanId), .tl_in_bits_opcode(tl_in_bits_opcode),
    .tl_in_bits_param(tl_in_bits_param), .tl_in_bits_corrupt(tl_in_bits_corrupt),
    .tl_in_bits_size(tl_in_bits_size), .tl_in_bits_union(tl_in_bits_union),
    .tl_in_bits_address(tl_in_bits_address), .tl_in_bits_data(tl_in_bits_data),
    .tl_in_bits_source(tl_in_bits_source), .tl_in_bits_last(tl_in_bits_last),
    .fifo_level(fifo_level), .drop_count(drop_count)
  );

  uart_tl_packet_queue_bridge #(.EDGE_QUAL(1'b0)) dut0 (
    .sysclk(sysclk), .reset(reset), .tl_clk(tl_clk0),
    .packet_valid(packet_valid0), .packet_ready(packet_ready0), .packet_data(packet_data0),
    .tl_ser_in_valid(tl_ser_in_valid0), .tl_ser_in_ready(tl_ser_in_ready0),
    .tl_in_bits_chanId(chan0), .tl_in_bits_opcode(opcode0),
    .tl_in_bits_param(param0), .tl_in_bits_corrupt(corrupt0),
    .tl_in_bits_size(size0), .tl_in_bits_union(union0),
    .tl_in_bits_address(address0), .tl_in_bits_data(data0),
    .tl_in_bits_source(source0), .tl_in_bits_last(last0),
    .fifo_level(fifo_level0), .drop_count(drop_count0)
  );

  initial sysclk = 1'b0;
  always #5 sysclk = ~sysclk;

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] mkPkt(input logic [7:0] b0, input logic [7:0] b1,
                                         input logic [7:0] sz, input logic [7:0] b3,
                                         input logic [31:0] addr, input logic [63:0] dat);
    return {dat, addr, b3, sz, b1, b0};
  endfunction

  function automatic logic [127:0] rndPkt(input logic [7:0] b0);
    return mkPkt(b0, 8'($urandom), 8'($urandom), 8'($urandom), $urandom, {$urandom, $urandom});
  endfunction

  function automatic logic [26:0] hdrOf(input logic [127:0] p);
    return {p[2:0], p[10:8], p[14:12], p[15], p[23:16], 1'b0, p[31:24]};
  endfunction

  task automatic checkHead(input string tag, input logic [127:0] p);
    checkOutput({tag, "_valid"}, 64'(tl_ser_in_valid), 64'd1);
    checkOutput({tag, "_hdr"}, 64'({tl_in_bits_chanId, tl_in_bits_opcode, tl_in_bits_param,
                 tl_in_bits_corrupt, tl_in_bits_size, tl_in_bits_union}), 64'(hdrOf(p)));
    checkOutput({tag, "_addr"}, tl_in_bits_address, {32'h0, p[63:32]});
    checkOutput({tag, "_data"}, tl_in_bits_data, p[127:64]);
  endtask

  // Offer one packet to the main instance and wait (bounded) for acceptance.
  task automatic applyStimulus(input logic [127:0] p, input bit legal);
    int n;
    @(negedge sysclk);
    packet_data  = p;
    packet_valid = 1'b1;
    n = 0;
    while (!packet_ready && n < 50) begin
      @(negedge sysclk);
      n++;
    end
    if (!packet_ready) checkOutput("push_timeout", 64'd0, 64'd1);
    @(posedge sysclk);
    if (legal && packet_ready) sb.push_back(p);
    #1 packet_valid = 1'b0;
  endtask

  task automatic tlPulse();
    @(negedge sysclk);
    tl_clk = 1'b1;
    repeat (4) @(negedge sysclk);
    tl_clk = 1'b0;
    repeat (4) @(negedge sysclk);
  endtask

  // Check the head frame against the scoreboard, give one tl_clk rise, expect one pop.
  task automatic drainOne(input string tag, input int expLevel);
    logic [127:0] p;
    if (sb.size() == 0) begin
      checkOutput({tag, "_sb_empty"}, 64'd0, 64'd1);
      return;
    end
    p = sb.pop_front();
    @(negedge sysclk);
    checkHead(tag, p);
    tlPulse();
    checkOutput({tag, "_level"}, 64'(fifo_level), 64'(expLevel));
  endtask

  initial begin
    logic [127:0] p;
    logic [127:0] q0 [3];
    reset = 1'b1;
    tl_clk = 1'b0;
    tl_clk0 = 1'b0;
    packet_valid = 1'b0;
    packet_data = '0;
    tl_ser_in_ready = 1'b0;
    packet_valid0 = 1'b0;
    packet_data0 = '0;
    tl_ser_in_ready0 = 1'b0;

    #12;
    checkOutput("rst_valid", 64'(tl_ser_in_valid), 64'd0);
    checkOutput("rst_level", 64'(fifo_level), 64'd0);
    checkOutput("rst_drop", 64'(drop_count), 64'd0);
    @(negedge sysclk);
    reset = 1'b0;
    @(negedge sysclk);
    checkOutput("rst_ready", 64'(packet_ready), 64'd1);

    // Test 1: single packet, latency and field decode
    $display("[TB] test 1: single packet decode");
    tl_ser_in_ready = 1'b1;
    p = mkPkt(8'h00, 8'hA4, 8'd3, 8'hFF, 32'h80001000, 64'h1122334455667788);
    applyStimulus(p, 1'b1);
    @(negedge sysclk);
    checkOutput("t1_valid", 64'(tl_ser_in_valid), 64'd1);
    checkOutput("t1_opcode", 64'(tl_in_bits_opcode), 64'd4);
    checkOutput("t1_param", 64'(tl_in_bits_param), 64'd2);
    checkOutput("t1_corrupt", 64'(tl_in_bits_corrupt), 64'd1);
    checkOutput("t1_size", 64'(tl_in_bits_size), 64'd3);
    checkOutput("t1_union", 64'(tl_in_bits_union), 64'h0FF);
    checkOutput("t1_addr", tl_in_bits_address, 64'h80001000);
    checkOutput("t1_data", tl_in_bits_data, 64'h1122334455667788);
    checkOutput("t1_source", 64'(tl_in_bits_source), 64'h00);
    checkOutput("t1_last", 64'(tl_in_bits_last), 64'd1);
    checkOutput("t1_level", 64'(fifo_level), 64'd1);
    drainOne("t1", 0);
    checkOutput("t1_empty", 64'(tl_ser_in_valid), 64'd0);

    // Test 2: fill to full with ready low, then drain while a fifth waits
    $display("[TB] test 2: full queue");
    tl_ser_in_ready = 1'b0;
    for (int i = 0; i < 4; i++) applyStimulus(rndPkt(i[0] ? 8'h03 : 8'h00), 1'b1);
    p = rndPkt(8'h03);
    @(negedge sysclk);
    packet_data  = p;
    packet_valid = 1'b1;
    @(negedge sysclk);
    checkOutput("t2_ready_full", 64'(packet_ready), 64'd0);
    checkOutput("t2_level_full", 64'(fifo_level), 64'd4);
    tl_ser_in_ready = 1'b1;
    repeat (3) @(negedge sysclk);
    drainOne("t2_f1", 4);
    sb.push_back(p);
    packet_valid = 1'b0;
    drainOne("t2_f2", 3);
    drainOne("t2_f3", 2);
    drainOne("t2_f4", 1);
    drainOne("t2_f5", 0);

    // Test 3: filtered channels and saturating drop counter
    $display("[TB] test 3: drops");
    applyStimulus(rndPkt(8'h05), 1'b0);
    applyStimulus(rndPkt(8'h08), 1'b0);
    @(negedge sysclk);
    checkOutput("t3_level", 64'(fifo_level), 64'd0);
    checkOutput("t3_drop2", 64'(drop_count), 64'd2);
    packet_data  = rndPkt(8'h01);
    packet_valid = 1'b1;
    repeat (65533) @(posedge sysclk);
    #1 packet_valid = 1'b0;
    @(negedge sysclk);
    checkOutput("t3_drop_max", 64'(drop_count), 64'hFFFF);
    packet_valid = 1'b1;
    repeat (3) @(posedge sysclk);
    #1 packet_valid = 1'b0;
    @(negedge sysclk);
    checkOutput("t3_drop_sat", 64'(drop_count), 64'hFFFF);
    checkOutput("t3_level2", 64'(fifo_level), 64'd0);

    // Test 4: push coincident with fire at level 2
    $display("[TB] test 4: coincident push and fire");
    applyStimulus(rndPkt(8'h00), 1'b1);
    applyStimulus(rndPkt(8'h03), 1'b1);
    p = rndPkt(8'h00);
    @(negedge sysclk);
    tl_clk = 1'b1;
    @(posedge sysclk);
    @(posedge sysclk);
    @(negedge sysclk);
    packet_data  = p;
    packet_valid = 1'b1;
    checkOutput("t4_level_before", 64'(fifo_level), 64'd2);
    checkHead("t4_head", sb[0]);
    @(posedge sysclk);
    void'(sb.pop_front());
    sb.push_back(p);
    #1 packet_valid = 1'b0;
    @(negedge sysclk);
    checkOutput("t4_level_after", 64'(fifo_level), 64'd2);
    repeat (2) @(negedge sysclk);
    tl_clk = 1'b0;
    repeat (4) @(negedge sysclk);
    drainOne("t4_o1", 1);
    drainOne("t4_o2", 0);

    // Test 5a: tl_clk held high gives no edge, so no fire
    $display("[TB] test 5: held tl_clk and free-running mode");
    @(negedge sysclk);
    tl_clk = 1'b1;
    repeat (6) @(negedge sysclk);
    applyStimulus(rndPkt(8'h03), 1'b1);
    repeat (6) @(negedge sysclk);
    checkOutput("t5_no_fire", 64'(fifo_level), 64'd1);
    tl_clk = 1'b0;
    repeat (4) @(negedge sysclk);
    drainOne("t5_drain", 0);

    // Test 5b: EDGE_QUAL=0 instance drains one frame per cycle
    for (int i = 0; i < 3; i++) begin
      q0[i] = rndPkt(i[0] ? 8'h03 : 8'h00);
      sb0.push_back(q0[i]);
    end
    @(negedge sysclk);
    packet_valid0 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      packet_data0 = q0[i];
      @(negedge sysclk);
    end
    packet_valid0 = 1'b0;
    checkOutput("t5_eq0_level", 64'(fifo_level0), 64'd3);
    tl_ser_in_ready0 = 1'b1;
    @(negedge sysclk);
    @(negedge sysclk);
    for (int i = 0; i < 3; i++) begin
      p = sb0.pop_front();
      checkOutput("t5_eq0_data", data0, p[127:64]);
      checkOutput("t5_eq0_lvl", 64'(fifo_level0), 64'(3 - i));
      @(negedge sysclk);
    end
    checkOutput("t5_eq0_empty", 64'(fifo_level0), 64'd0);
    checkOutput("t5_eq0_valid", 64'(tl_ser_in_valid0), 64'd0);

    // Test 6: asynchronous reset with three frames queued
    $display("[TB] test 6: reset mid-queue");
    tl_ser_in_ready = 1'b0;
    for (int i = 0; i < 3; i++) applyStimulus(rndPkt(8'h00), 1'b1);
    @(negedge sysclk);
    checkOutput("t6_level3", 64'(fifo_level), 64'd3);
    #2 reset = 1'b1;
    #1;
    checkOutput("t6_valid", 64'(tl_ser_in_valid), 64'd0);
    checkOutput("t6_level", 64'(fifo_level), 64'd0);
    checkOutput("t6_drop", 64'(drop_count), 64'd0);
    sb.delete();
    @(negedge sysclk);
    reset = 1'b0;
    @(negedge sysclk);
    checkOutput("t6_ready", 64'(packet_ready), 64'd1);
    tl_ser_in_ready = 1'b1;
    applyStimulus(rndPkt(8'h03), 1'b1);
    repeat (3) @(negedge sysclk);
    drainOne("t6_post", 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
